// File: rtl/rerouting_decoder_rv32i.sv
// RV32I scalar/vector move rerouting decoder.
// Same-cycle control word plus a registered copy and an illegal flag.
module rerouting_decoder_rv32i (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       STV,
  input  logic       VTS,
  input  logic       f7_eq_0x1,
  input  logic       f7_eq_0x2,
  input  logic       f7_eq_0x3,
  output logic       rerouting_select,
  output logic [2:0] rerouting_code,
  output logic       rerouting_select_q,
  output logic [2:0] rerouting_code_q,
  output logic       illegal_q
);

  logic       sel;
  logic [2:0] code;
  logic [2:0] flags;
  logic       none_hot;
  logic       multi_hot;
  logic       illegal;

  assign flags = {f7_eq_0x3, f7_eq_0x2, f7_eq_0x1};
  assign sel   = STV | VTS;

  always_comb begin
    code = 3'b000;
    if (sel) begin
      code[2] = VTS;
      code[1] = f7_eq_0x2;
      code[0] = f7_eq_0x1 | f7_eq_0x3;
    end
  end

  // Exactly one funct7 flag is expected with an active move.
  assign none_hot  = (flags == 3'b000);
  assign multi_hot = (flags & (flags - 3'd1)) != 3'b000;

  assign illegal = (STV & VTS)
                 | (sel & multi_hot)
                 | (sel & none_hot);

  assign rerouting_select = sel;
  assign rerouting_code   = code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rerouting_select_q <= 1'b0;
      rerouting_code_q   <= 3'b000;
      illegal_q          <= 1'b0;
    end else begin
      rerouting_select_q <= sel;
      rerouting_code_q   <= code;
      illegal_q          <= illegal;
    end
  end

endmodule

// File: tb/tb_rerouting_decoder_rv32i.sv
// Scoreboard bench for rerouting_decoder_rv32i.
// Reference model works from move/flag counts, not the RTL terms.
module tb_rerouting_decoder_rv32i;

  logic       clk;
  logic       rst_n;
  logic       STV;
  logic       VTS;
  logic       f7_eq_0x1;
  logic       f7_eq_0x2;
  logic       f7_eq_0x3;
  logic       rerouting_select;
  logic [2:0] rerouting_code;
  logic       rerouting_select_q;
  logic [2:0] rerouting_code_q;
  logic       illegal_q;

  int checks = 0;
  int errors = 0;
  bit done = 0;

  // {select, code[2:0], illegal}
  logic [4:0] exp_q[$];

  rerouting_decoder_rv32i dut (
    .clk(clk),
    .rst_n(rst_n),
    .STV(STV),
    .VTS(VTS),
    .f7_eq_0x1(f7_eq_0x1),
    .f7_eq_0x2(f7_eq_0x2),
    .f7_eq_0x3(f7_eq_0x3),
    .rerouting_select(rerouting_select),
    .rerouting_code(rerouting_code),
    .rerouting_select_q(rerouting_select_q),
    .rerouting_code_q(rerouting_code_q),
    .illegal_q(illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model(
    input bit s, input bit v,
    input bit a, input bit b, input bit c
  );
    int moves;
    int nflags;
    int code;
    bit ill;
    moves  = int'(s) + int'(v);
    nflags = int'(a) + int'(b) + int'(c);
    code   = 0;
    if (moves > 0)
      code = 4 * int'(v) + 2 * int'(b) + ((a || c) ? 1 : 0);
    ill = (moves == 2) || (moves > 0 && nflags != 1);
    return {moves > 0, code[2:0], ill};
  endfunction

  task automatic check(
    input string name, input logic [4:0] act, input logic [4:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge.
  task automatic apply(
    input bit s, input bit v,
    input bit a, input bit b, input bit c,
    input bit rst
  );
    logic [4:0] e;
    @(negedge clk);
    STV = s; VTS = v;
    f7_eq_0x1 = a; f7_eq_0x2 = b; f7_eq_0x3 = c;
    rst_n = rst;
    e = model(s, v, a, b, c);
    #1;
    check("comb", {rerouting_select, rerouting_code, 1'b0},
          {e[4:1], 1'b0});
    if (!rst) begin
      check("async_rst",
            {rerouting_select_q, rerouting_code_q, illegal_q}, 5'b0);
      exp_q.push_back(5'b0);
    end else begin
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare registered outputs after every rising edge.
  initial begin
    logic [4:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("regs",
              {rerouting_select_q, rerouting_code_q, illegal_q}, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    STV = 0; VTS = 0;
    f7_eq_0x1 = 0; f7_eq_0x2 = 0; f7_eq_0x3 = 0;
    #2;
    check("reset",
          {rerouting_select_q, rerouting_code_q, illegal_q}, 5'b0);

    apply(1, 0, 0, 0, 1, 1);
    apply(0, 1, 0, 1, 1, 1);
    apply(0, 0, 1, 1, 1, 1);
    apply(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      apply(0, 1, 0, 1, 0, 1);
    // Reset dropped between edges with VTS/0x2 held.
    apply(0, 1, 0, 1, 0, 0);
    apply(0, 1, 0, 1, 0, 0);
    apply(0, 1, 0, 1, 0, 1);
    apply(1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] r;
      r = 5'($urandom);
      apply(r[0], r[1], r[2], r[3], r[4],
            $urandom_range(0, 19) != 0);
    end

    apply(0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
